// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the tiled matrix-multiply scheduler.
package matmul_pkg;

  localparam int MM_N         = 16;
  localparam int MM_TILE      = 4;
  localparam int MM_AW        = $clog2(MM_N);
  localparam int MM_SKEW      = 2 * MM_TILE - 2;
  localparam int MM_NUM_TILES = (MM_N / MM_TILE) * (MM_N / MM_TILE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/tile_index_walker.sv
// Row-major walk over output tile bases (tr, tc); flags the final tile of a run.
module tile_index_walker #(
  parameter int N    = matmul_pkg::MM_N,
  parameter int TILE = matmul_pkg::MM_TILE,
  parameter int AW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_advance,
  output logic [AW-1:0] o_tr,
  output logic [AW-1:0] o_tc,
  output logic          o_last_tile
);

  localparam logic [AW-1:0] LAST_BASE = AW'(N - TILE);
  localparam logic [AW-1:0] STEP      = AW'(TILE);

  logic [AW-1:0] r_tr;
  logic [AW-1:0] r_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tr <= '0;
      r_tc <= '0;
    end else if (i_start) begin
      r_tr <= '0;
      r_tc <= '0;
    end else if (i_advance) begin
      if (r_tc == LAST_BASE) begin
        r_tc <= '0;
        r_tr <= r_tr + STEP;
      end else begin
        r_tc <= r_tc + STEP;
      end
    end
  end

  assign o_tr        = r_tr;
  assign o_tc        = r_tc;
  assign o_last_tile = (r_tr == LAST_BASE) && (r_tc == LAST_BASE);

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer: clear, feed K operand beats, flush systolic skew, drain TILE rows per tile.
module matmul_tile_scheduler
  import matmul_pkg::*;
#(
  parameter int N    = MM_N,
  parameter int TILE = MM_TILE,
  parameter int AW   = $clog2(N),
  parameter int SKEW = 2 * TILE - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          arr_clear,
  output logic          feed_valid,
  input  logic          feed_ready,
  output logic [AW-1:0] feed_k,
  output logic [AW-1:0] tile_row,
  output logic [AW-1:0] tile_col,
  output logic          drain_valid,
  input  logic          drain_ready,
  output logic [AW-1:0] drain_row,
  output logic [31:0]   cycle_count
);

  if ((N % TILE) != 0 || TILE < 2) begin : g_param_check
    $error("matmul_tile_scheduler: N must be a multiple of TILE and TILE must be >= 2");
  end

  localparam int            FW     = (SKEW > 1) ? $clog2(SKEW) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(N - 1);
  localparam logic [AW-1:0] I_LAST = AW'(TILE - 1);

  state_t        r_state;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_i;
  logic [FW-1:0] r_flush;
  logic [31:0]   r_cycles;

  logic          w_walk_start;
  logic          w_advance;
  logic          w_last_tile;
  logic          w_drain_last;
  logic [AW-1:0] w_tr;
  logic [AW-1:0] w_tc;

  assign w_walk_start = (r_state == ST_IDLE) && start;
  assign w_drain_last = (r_state == ST_DRAIN) && drain_ready && (r_i == I_LAST);
  // The final tile does not advance, so tile_row/tile_col keep their last values after FIN.
  assign w_advance    = w_drain_last && !w_last_tile;

  tile_index_walker #(
    .N    (N),
    .TILE (TILE),
    .AW   (AW)
  ) u_walker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_walk_start),
    .i_advance   (w_advance),
    .o_tr        (w_tr),
    .o_tc        (w_tc),
    .o_last_tile (w_last_tile)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_i      <= '0;
      r_flush  <= '0;
      r_cycles <= '0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_cycles <= r_cycles + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_CLEAR;
            r_cycles <= '0;
            r_i      <= '0;
          end
        end
        ST_CLEAR: begin
          r_k     <= '0;
          r_state <= ST_FEED;
        end
        ST_FEED: begin
          if (feed_ready) begin
            if (r_k == K_LAST) begin
              r_state <= ST_FLUSH;
              r_flush <= FW'(SKEW - 1);
            end else begin
              r_k <= r_k + AW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush == '0) begin
            r_state <= ST_DRAIN;
            r_i     <= '0;
          end else begin
            r_flush <= r_flush - FW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_ready) begin
            if (r_i == I_LAST) begin
              r_state <= w_last_tile ? ST_FIN : ST_CLEAR;
            end else begin
              r_i <= r_i + AW'(1);
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign arr_clear   = (r_state == ST_CLEAR);
  assign feed_valid  = (r_state == ST_FEED);
  assign drain_valid = (r_state == ST_DRAIN);
  assign feed_k      = r_k;
  assign tile_row    = w_tr;
  assign tile_col    = w_tc;
  assign drain_row   = w_tr + r_i;
  assign cycle_count = r_cycles;

endmodule
